// File: rtl/vga_frame_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates, validates sync timing, tracks lock.
// Optional per-frame CRC-16/CCITT of active pixels when FRAME_CRC_EN is defined.
module vga_frame_monitor #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BP        = 33,
   parameter logic        SYNC_ACT    = 1'b0,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        pix_ce,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [15:0] rgb,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [15:0] pix_rgb,
   output logic        frame_done,
   output logic        locked,
   output logic        h_err,
   output logic        v_err,
   output logic [7:0]  err_cnt,
   output logic [15:0] frame_crc
);

   localparam logic [10:0] H_TOTAL = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam logic [10:0] V_TOTAL = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
   localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
   localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [10:0] V_START = 11'(V_SYNC + V_BP);
   localparam logic [10:0] V_END   = 11'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_t;

   state_t      state_q, state_d;
   logic        hs_prev_q, vs_prev_q;
   logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [3:0]  good_q, good_d;
   logic        dirty_q, dirty_d;
   logic        h_seen_q, h_seen_d;
   logic        hs_edge, vs_edge, h_err_c, v_err_c, any_err, in_win;
   logic [10:0] h_off, v_off;

   always_comb begin
      hs_edge = pix_ce && (hsync == SYNC_ACT) && (hs_prev_q != SYNC_ACT);
      vs_edge = pix_ce && (vsync == SYNC_ACT) && (vs_prev_q != SYNC_ACT);
      // Length checks always look at the counts before this sample resets them.
      h_err_c = hs_edge && h_seen_q && (({1'b0, h_cnt_q} + 11'd1) != H_TOTAL);
      v_err_c = vs_edge && (state_q != StSearch) && (({1'b0, v_cnt_q} + 11'd1) != V_TOTAL);
      any_err = h_err_c || v_err_c;

      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (pix_ce) begin
         if (hs_edge)                 h_cnt_d = 10'd0;
         else if (h_cnt_q != 10'h3FF) h_cnt_d = h_cnt_q + 10'd1;
         if (vs_edge)                            v_cnt_d = 10'd0;
         else if (hs_edge && v_cnt_q != 10'h3FF) v_cnt_d = v_cnt_q + 10'd1;
      end

      h_off  = {1'b0, h_cnt_d} - H_START;
      v_off  = {1'b0, v_cnt_d} - V_START;
      in_win = pix_ce && (state_q != StSearch)
               && ({1'b0, h_cnt_d} >= H_START) && ({1'b0, h_cnt_d} < H_END)
               && ({1'b0, v_cnt_d} >= V_START) && ({1'b0, v_cnt_d} < V_END);

      state_d  = state_q;
      good_d   = good_q;
      h_seen_d = h_seen_q || hs_edge;
      // A frame is clean only if no error occurred anywhere since the last vs_edge.
      dirty_d  = vs_edge ? 1'b0 : (dirty_q || any_err);
      case (state_q)
         StSearch: begin
            if (vs_edge) begin
               state_d = StTrack;
               good_d  = 4'd0;
            end
         end
         StTrack: begin
            if (vs_edge) begin
               if (any_err || dirty_q) begin
                  good_d = 4'd0;
               end else begin
                  good_d = good_q + 4'd1;
                  if (good_q + 4'd1 == LOCK_N) state_d = StLocked;
               end
            end else if (any_err) begin
               good_d = 4'd0;
            end
         end
         StLocked: begin
            if (any_err) begin
               state_d  = StSearch;
               h_seen_d = 1'b0;
            end
         end
         default: state_d = StSearch;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= StSearch;
         hs_prev_q  <= ~SYNC_ACT;
         vs_prev_q  <= ~SYNC_ACT;
         h_cnt_q    <= 10'd0;
         v_cnt_q    <= 10'd0;
         good_q     <= 4'd0;
         dirty_q    <= 1'b0;
         h_seen_q   <= 1'b0;
         pix_valid  <= 1'b0;
         pix_x      <= 10'd0;
         pix_y      <= 10'd0;
         pix_rgb    <= 16'd0;
         frame_done <= 1'b0;
         locked     <= 1'b0;
         h_err      <= 1'b0;
         v_err      <= 1'b0;
         err_cnt    <= 8'd0;
      end else begin
         state_q    <= state_d;
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         good_q     <= good_d;
         dirty_q    <= dirty_d;
         h_seen_q   <= h_seen_d;
         frame_done <= vs_edge;
         h_err      <= h_err_c;
         v_err      <= v_err_c;
         locked     <= (state_d == StLocked);
         if (any_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         if (pix_ce) begin
            hs_prev_q <= hsync;
            vs_prev_q <= vsync;
            pix_valid <= in_win;
            pix_x     <= in_win ? h_off[9:0] : 10'd0;
            pix_y     <= in_win ? v_off[9:0] : 10'd0;
            pix_rgb   <= in_win ? rgb : 16'd0;
         end
      end
   end

`ifdef FRAME_CRC_EN
   logic [15:0] crc_acc_q;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 15; i >= 0; i--) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return r;
   endfunction

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         crc_acc_q <= 16'hFFFF;
         frame_crc <= 16'h0000;
      end else if (vs_edge) begin
         frame_crc <= crc_acc_q;
         crc_acc_q <= 16'hFFFF;
      end else if (in_win) begin
         crc_acc_q <= crc_step(crc_acc_q, rgb);
      end
   end
`else
   assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor: reduced video mode, raster-level model checked every cycle,
// plus literal checks on lock, error counting, frame period and CRC.
module tb_vga_frame_monitor;

   localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
   localparam int VA = 6, VFP = 1, VS = 2, VBP = 2;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int LF = 2;
   localparam logic SA = 1'b0;
`ifdef FRAME_CRC_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   logic sys_clk = 1'b0, sys_rst_n = 1'b1, pix_ce = 1'b0, hsync = 1'b1, vsync = 1'b1;
   logic [15:0] rgb = 16'd0;
   logic pix_valid, frame_done, locked, h_err, v_err;
   logic [9:0] pix_x, pix_y;
   logic [15:0] pix_rgb, frame_crc;
   logic [7:0] err_cnt;

   vga_frame_monitor #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SYNC_ACT(SA), .LOCK_FRAMES(LF)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_ce(pix_ce), .hsync(hsync), .vsync(vsync),
      .rgb(rgb), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
      .frame_done(frame_done), .locked(locked), .h_err(h_err), .v_err(v_err),
      .err_cnt(err_cnt), .frame_crc(frame_crc)
   );

   always #5 sys_clk = ~sys_clk;

   int n_chk = 0, n_fail = 0;
   bit chk_en = 1'b0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // ---------------- model: raster position in plain integers ----------------
   logic m_hs_prev, m_vs_prev;
   int   m_h, m_v, m_phase, m_good, m_ec;  // phase 0 search, 1 tracking, 2 locked
   bit   m_hseen, m_dirty;
   logic [15:0] m_acc, m_crc_out;
   logic e_pv, e_fd, e_loc, e_he, e_ve;
   logic [9:0] e_x, e_y;
   logic [15:0] e_rgb, e_crc;
   logic [7:0] e_ec;

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] w);
      return crc_byte(crc_byte(c, w[15:8]), w[7:0]);
   endfunction

   task model_reset();
      m_hs_prev = ~SA; m_vs_prev = ~SA;
      m_h = 0; m_v = 0; m_phase = 0; m_good = 0; m_ec = 0;
      m_hseen = 0; m_dirty = 0; m_acc = 16'hFFFF; m_crc_out = 16'h0;
      e_pv = 0; e_fd = 0; e_loc = 0; e_he = 0; e_ve = 0;
      e_x = 0; e_y = 0; e_rgb = 0; e_crc = 0; e_ec = 0;
   endtask

   task model_step(input logic h, input logic v, input logic [15:0] d);
      bit hs_e, vs_e, he, ve, err, win;
      int nh, nv;
      hs_e = (h == SA) && (m_hs_prev != SA);
      vs_e = (v == SA) && (m_vs_prev != SA);
      m_hs_prev = h; m_vs_prev = v;
      he  = hs_e && m_hseen && (m_h + 1 != HT);
      ve  = vs_e && (m_phase != 0) && (m_v + 1 != VT);
      err = he || ve;
      nh  = hs_e ? 0 : ((m_h < 1023) ? m_h + 1 : 1023);
      nv  = vs_e ? 0 : (hs_e ? ((m_v < 1023) ? m_v + 1 : 1023) : m_v);
      win = (m_phase != 0) && nh >= HS + HBP && nh < HS + HBP + HA
            && nv >= VS + VBP && nv < VS + VBP + VA;
      e_pv  = win;
      e_x   = win ? 10'(nh - (HS + HBP)) : 10'd0;
      e_y   = win ? 10'(nv - (VS + VBP)) : 10'd0;
      e_rgb = win ? d : 16'd0;
      if (vs_e) begin
         m_crc_out = m_acc;
         m_acc     = 16'hFFFF;
      end else if (win) begin
         m_acc = crc_word(m_acc, d);
      end
      e_crc = CRC_ON ? m_crc_out : 16'h0;
      if (hs_e) m_hseen = 1;
      case (m_phase)
         0: if (vs_e) begin m_phase = 1; m_good = 0; end
         1: begin
            if (vs_e) begin
               if (err || m_dirty) m_good = 0;
               else begin
                  m_good++;
                  if (m_good == LF) m_phase = 2;
               end
            end else if (err) m_good = 0;
         end
         default: if (err) begin m_phase = 0; m_hseen = 0; end
      endcase
      m_dirty = vs_e ? 0 : (m_dirty || err);
      m_h = nh; m_v = nv;
      if (err && m_ec < 255) m_ec++;
      e_fd = vs_e; e_he = he; e_ve = ve; e_loc = (m_phase == 2); e_ec = 8'(m_ec);
   endtask

   // ---------------- every-cycle compare ----------------
   always @(posedge sys_clk) cyc++;

   always @(negedge sys_clk) begin
      if (chk_en) begin
         chk("pix_valid", 32'(pix_valid), 32'(e_pv));
         chk("pix_x", 32'(pix_x), 32'(e_x));
         chk("pix_y", 32'(pix_y), 32'(e_y));
         chk("pix_rgb", 32'(pix_rgb), 32'(e_rgb));
         chk("frame_done", 32'(frame_done), 32'(e_fd));
         chk("locked", 32'(locked), 32'(e_loc));
         chk("h_err", 32'(h_err), 32'(e_he));
         chk("v_err", 32'(v_err), 32'(e_ve));
         chk("err_cnt", 32'(err_cnt), 32'(e_ec));
         chk("frame_crc", 32'(frame_crc), 32'(e_crc));
      end
   end

   int fd_cnt = 0, errp_cnt = 0;
   int fd_times[$];
   bit seen_valid = 0;
   logic [9:0] fv_x, fv_y;
   logic [15:0] fv_rgb;
   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (frame_done) begin fd_cnt++; fd_times.push_back(cyc); end
         if (h_err || v_err) errp_cnt++;
         if (pix_valid && !seen_valid) begin
            seen_valid = 1; fv_x = pix_x; fv_y = pix_y; fv_rgb = pix_rgb;
         end
      end
   end

   // ---------------- stimulus ----------------
   task send(input logic h, input logic v, input logic [15:0] d);
      hsync = h; vsync = v; rgb = d; pix_ce = 1'b1;
      @(posedge sys_clk); #1;
      model_step(h, v, d);
      pix_ce = 1'b0;
      @(posedge sys_clk); #1;
      e_fd = 0; e_he = 0; e_ve = 0;
   endtask

   // mode 0: rgb = active column, 1: constant red, 2: random
   task gen_lines(input int start, input int n, input int short_idx, input int short_len,
                  input int mode);
      int len;
      logic [15:0] d;
      for (int l = start; l < start + n; l++) begin
         len = (l == short_idx) ? short_len : HT;
         for (int c = 0; c < len; c++) begin
            if (mode == 0)
               d = (c >= HS + HBP && c < HS + HBP + HA) ? 16'(c - (HS + HBP)) : 16'h0;
            else if (mode == 1) d = 16'hF800;
            else d = 16'($urandom);
            send((c < HS) ? SA : ~SA, (l < VS) ? SA : ~SA, d);
         end
      end
   endtask

   task gen_frame(input int mode);
      gen_lines(0, VT, -1, 0, mode);
   endtask

   initial begin
      int fd0, ep0;
      string s;
      logic [15:0] c, exp_crc;

      // model pin: CRC-16/CCITT-FALSE of "123456789"
      s = "123456789";
      c = 16'hFFFF;
      for (int i = 0; i < 9; i++) c = crc_byte(c, s[i]);
      chk("model_crc_check_value", 32'(c), 32'h29B1);

      // reset held with random inputs
      model_reset();
      #1 sys_rst_n = 1'b0;
      #2 chk_en = 1'b1;
      repeat (20) begin
         @(posedge sys_clk); #1;
         pix_ce = 1'($urandom); hsync = 1'($urandom); vsync = 1'($urandom); rgb = 16'($urandom);
      end
      @(posedge sys_clk); #1;
      pix_ce = 1'b0; hsync = ~SA; vsync = ~SA;
      sys_rst_n = 1'b1;
      repeat (5) send(~SA, ~SA, 16'($urandom));
      chk("idle_after_release_locked", 32'(locked), 32'd0);

      // clean frames, rgb = column
      gen_frame(0);
      gen_frame(0);
      chk("not_locked_after_2_vs", 32'(locked), 32'd0);
      gen_frame(0);
      gen_frame(0);
      chk("locked_after_3_vs", 32'(locked), 32'd1);
      chk("frame_done_count", 32'(fd_cnt), 32'd4);
      chk("frame_period_cycles", 32'(fd_times[1] - fd_times[0]), 32'(2 * HT * VT));
      chk("first_valid_seen", 32'(seen_valid), 32'd1);
      chk("first_valid_xy_rgb", {2'b0, fv_x, fv_y, fv_rgb[9:0]}, 32'd0);
      chk("no_errors_clean", 32'(err_cnt), 32'd0);

      // one short line while locked
      gen_lines(0, VT, 3, HT - 1, 0);
      chk("short_line_err_cnt", 32'(err_cnt), 32'd1);
      chk("short_line_unlock", 32'(locked), 32'd0);
      gen_frame(0);
      gen_frame(0);
      gen_frame(0);
      chk("relocked", 32'(locked), 32'd1);

      // short frame, reported at the next vs_edge
      gen_lines(0, VT - 1, -1, 0, 0);
      chk("short_frame_pending", 32'(err_cnt), 32'd1);
      gen_frame(0);
      chk("short_frame_err_cnt", 32'(err_cnt), 32'd2);
      chk("short_frame_unlock", 32'(locked), 32'd0);

      // 300 short lines drive err_cnt into saturation
      for (int i = 0; i < 300; i++)
         for (int cc = 0; cc < 5; cc++) send((cc < HS) ? SA : ~SA, ~SA, 16'h0);
      chk("err_cnt_saturated", 32'(err_cnt), 32'd255);

      // coincident hs/vs edges: exactly one frame_done per frame, no spurious errors
      fd0 = fd_cnt;
      gen_frame(2);
      ep0 = errp_cnt;
      gen_frame(2);
      gen_frame(2);
      chk("coincident_frame_done", 32'(fd_cnt - fd0), 32'd3);
      chk("coincident_no_err", 32'(errp_cnt - ep0), 32'd0);
      chk("coincident_relock", 32'(locked), 32'd1);
      chk("err_cnt_stays_255", 32'(err_cnt), 32'd255);

      // constant-red frame CRC
      gen_frame(1);
      gen_lines(0, 1, -1, 0, 1);
      exp_crc = 16'hFFFF;
      for (int i = 0; i < HA * VA; i++) exp_crc = crc_word(exp_crc, 16'hF800);
      chk("red_frame_crc", 32'(frame_crc), CRC_ON ? 32'(exp_crc) : 32'd0);
      gen_lines(1, VT - 1, -1, 0, 1);

      // reset mid-frame, then partial frame must not flag anything
      gen_lines(0, 5, -1, 0, 2);
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      chk("mid_reset_err_cnt", 32'(err_cnt), 32'd0);
      gen_lines(5, VT - 5, -1, 0, 2);
      gen_frame(2);
      gen_frame(2);
      gen_frame(2);
      chk("mid_reset_no_errors", 32'(err_cnt), 32'd0);
      chk("mid_reset_relock", 32'(locked), 32'd1);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
